vx_issue_scheduler: RTL and testbench

// - Parametrised multi-warp issue scheduler for one issue slice. It sits between the
//   per-warp instruction buffers and operand collection.
// - Each cycle it tracks per-warp register hazards with a pending-bit scoreboard.
// - It selects one hazard-free warp head using round-robin or fixed-priority

---
 rtl/vx_issue_pkg.sv | 27 ++
 rtl/vx_issue_rr_arbiter.sv | 47 ++++
 rtl/vx_issue_scheduler.sv | 128 ++++++++++++
 tb/tb_vx_issue_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_issue_pkg.sv
// Shared types and constants for the issue scheduler slice.
// issue_cand_t is sized for the default slice configuration.
package vx_issue_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned DEF_NUM_WARPS = 4;
    localparam int unsigned DEF_NUM_REGS  = 64;
    localparam int unsigned DEF_NUM_EX    = 4;
    localparam int unsigned DEF_PAYLOAD_W = 64;

    localparam int unsigned DEF_WB = $clog2(DEF_NUM_WARPS);
    localparam int unsigned DEF_RB = $clog2(DEF_NUM_REGS);
    localparam int unsigned DEF_EB = $clog2(DEF_NUM_EX);

    typedef struct packed {
        logic                     wb;
        logic [DEF_RB-1:0]        rd;
        logic [DEF_RB-1:0]        rs1;
        logic [DEF_RB-1:0]        rs2;
        logic [DEF_RB-1:0]        rs3;
        logic [DEF_EB-1:0]        ex;
        logic [DEF_PAYLOAD_W-1:0] payload;
    } issue_cand_t;

endpackage

// File: rtl/vx_issue_rr_arbiter.sv
// Request vector to one-hot grant; round-robin from an internal pointer
// or fixed priority (lowest index wins), chosen by ARB_MODE.
module vx_issue_rr_arbiter
    import vx_issue_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ARB_MODE = ARB_RR,
    localparam int unsigned PB      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    logic [PB-1:0] ptr;
    logic [PB-1:0] grant_idx;
    logic          found;

    function automatic int unsigned idx_of(input int unsigned i, input logic [PB-1:0] p);
        if (ARB_MODE == ARB_FIXED)
            return i;
        else
            return (32'(p) + i) % NUM_REQ;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx_of(i, ptr)]) begin
                grant[idx_of(i, ptr)] = 1'b1;
                grant_idx             = PB'(idx_of(i, ptr));
                found                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (found)
            ptr <= (grant_idx == PB'(NUM_REQ - 1)) ? '0 : grant_idx + PB'(1);
    end

endmodule

// File: rtl/vx_issue_scheduler.sv
// Multi-warp issue scheduler: pending-bit scoreboard, warp arbitration and a
// single-entry elastic dispatch register with combinational zero-bubble grant.
module vx_issue_scheduler
    import vx_issue_pkg::*;
#(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned NUM_REGS  = 64,
    parameter int unsigned NUM_EX    = 4,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned ARB_MODE  = ARB_RR,
    parameter int unsigned WB_BYPASS = 1,
    localparam int unsigned WB = $clog2(NUM_WARPS),
    localparam int unsigned RB = $clog2(NUM_REGS),
    localparam int unsigned EB = $clog2(NUM_EX)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WARPS-1:0]           cand_valid,
    input  logic [NUM_WARPS-1:0]           cand_wb,
    input  logic [NUM_WARPS*RB-1:0]        cand_rd,
    input  logic [NUM_WARPS*RB-1:0]        cand_rs1,
    input  logic [NUM_WARPS*RB-1:0]        cand_rs2,
    input  logic [NUM_WARPS*RB-1:0]        cand_rs3,
    input  logic [NUM_WARPS*EB-1:0]        cand_ex,
    input  logic [NUM_WARPS*PAYLOAD_W-1:0] cand_payload,
    output logic [NUM_WARPS-1:0]           cand_ready,
    input  logic                           wb_valid,
    input  logic [WB-1:0]                  wb_wid,
    input  logic [RB-1:0]                  wb_rd,
    input  logic                           wb_eop,
    output logic                           disp_valid,
    output logic [WB-1:0]                  disp_wid,
    output logic [EB-1:0]                  disp_ex,
    output logic [PAYLOAD_W-1:0]           disp_payload,
    input  logic                           disp_ready,
    output logic [31:0]                    perf_stalls
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] wb_clr;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_view;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_set;
    logic [NUM_WARPS-1:0]               eligible;
    logic [NUM_WARPS-1:0]               req;
    logic [NUM_WARPS-1:0]               grant;
    logic                               free;

    logic                 sel_wb;
    logic [RB-1:0]        sel_rd;
    logic [WB-1:0]        sel_wid;
    logic [EB-1:0]        sel_ex;
    logic [PAYLOAD_W-1:0] sel_payload;

    always_comb begin
        wb_clr = '0;
        if (wb_valid && wb_eop)
            wb_clr[wb_wid][wb_rd] = 1'b1;
        pend_view = (WB_BYPASS != 0) ? (pending & ~wb_clr) : pending;
    end

    always_comb begin
        eligible = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = cand_valid[w]
                && !pend_view[w][cand_rs1[w*RB +: RB]]
                && !pend_view[w][cand_rs2[w*RB +: RB]]
                && !pend_view[w][cand_rs3[w*RB +: RB]]
                && !(cand_wb[w] && pend_view[w][cand_rd[w*RB +: RB]]);
        end
    end

    assign free       = !disp_valid || disp_ready;
    assign req        = (reset || !free) ? '0 : eligible;
    assign cand_ready = grant;

    vx_issue_rr_arbiter #(
        .NUM_REQ  (NUM_WARPS),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    always_comb begin
        sel_wb      = 1'b0;
        sel_rd      = '0;
        sel_wid     = '0;
        sel_ex      = '0;
        sel_payload = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (grant[w]) begin
                sel_wb      = cand_wb[w];
                sel_rd      = cand_rd[w*RB +: RB];
                sel_wid     = WB'(w);
                sel_ex      = cand_ex[w*EB +: EB];
                sel_payload = cand_payload[w*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        // r0 is never marked pending, so it can never cause a stall
        pend_set = '0;
        if (sel_wb && sel_rd != '0)
            pend_set[sel_wid][sel_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            disp_valid  <= 1'b0;
            perf_stalls <= '0;
        end else begin
            // set applied after clear so a same-cycle set of (w, rd) wins
            pending <= (pending & ~wb_clr) | pend_set;
            if (|grant) begin
                disp_valid   <= 1'b1;
                disp_wid     <= sel_wid;
                disp_ex      <= sel_ex;
                disp_payload <= sel_payload;
            end else if (disp_ready) begin
                disp_valid <= 1'b0;
            end
            if (|cand_valid && !(|grant))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end

endmodule

// File: tb/tb_vx_issue_scheduler.sv
// Bench for vx_issue_scheduler: two instances (RR+bypass, fixed+no-bypass)
// driven identically and compared each cycle against a per-instance model.
module tb_vx_issue_scheduler;
    import vx_issue_pkg::*;

    localparam int NW = 4, NR = 64, PW = 64, WBW = 2, RB = 6, EB = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     cand_valid, cand_wb;
    logic [NW*RB-1:0]  cand_rd, cand_rs1, cand_rs2, cand_rs3;
    logic [NW*EB-1:0]  cand_ex;
    logic [NW*PW-1:0]  cand_payload;
    logic              wb_valid, wb_eop;
    logic [WBW-1:0]    wb_wid;
    logic [RB-1:0]     wb_rd;
    logic              disp_ready;

    logic [NW-1:0]     cr  [2];
    logic              dv  [2];
    logic [WBW-1:0]    dw  [2];
    logic [EB-1:0]     dx  [2];
    logic [PW-1:0]     dp  [2];
    logic [31:0]       ps  [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vx_issue_scheduler #(
        .NUM_WARPS(NW), .NUM_REGS(NR), .NUM_EX(4), .PAYLOAD_W(PW),
        .ARB_MODE(ARB_RR), .WB_BYPASS(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .cand_valid(cand_valid), .cand_wb(cand_wb),
        .cand_rd(cand_rd), .cand_rs1(cand_rs1), .cand_rs2(cand_rs2), .cand_rs3(cand_rs3),
        .cand_ex(cand_ex), .cand_payload(cand_payload), .cand_ready(cr[0]),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .disp_valid(dv[0]), .disp_wid(dw[0]), .disp_ex(dx[0]), .disp_payload(dp[0]),
        .disp_ready(disp_ready), .perf_stalls(ps[0])
    );

    vx_issue_scheduler #(
        .NUM_WARPS(NW), .NUM_REGS(NR), .NUM_EX(4), .PAYLOAD_W(PW),
        .ARB_MODE(ARB_FIXED), .WB_BYPASS(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .cand_valid(cand_valid), .cand_wb(cand_wb),
        .cand_rd(cand_rd), .cand_rs1(cand_rs1), .cand_rs2(cand_rs2), .cand_rs3(cand_rs3),
        .cand_ex(cand_ex), .cand_payload(cand_payload), .cand_ready(cr[1]),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .disp_valid(dv[1]), .disp_wid(dw[1]), .disp_ex(dx[1]), .disp_payload(dp[1]),
        .disp_ready(disp_ready), .perf_stalls(ps[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          mp   [2][NW][NR];
    int          mptr [2];
    bit          mdv  [2];
    int          mwid [2];
    logic [EB-1:0] mex [2];
    logic [PW-1:0] mpay[2];
    logic [31:0] mst  [2];
    int          mwin [2];
    int          marb [2] = '{ARB_RR, ARB_FIXED};
    bit          mbyp [2] = '{1'b1, 1'b0};

    function automatic issue_cand_t cand_of(input int w);
        issue_cand_t c;
        c.wb      = cand_wb[w];
        c.rd      = cand_rd[w*RB +: RB];
        c.rs1     = cand_rs1[w*RB +: RB];
        c.rs2     = cand_rs2[w*RB +: RB];
        c.rs3     = cand_rs3[w*RB +: RB];
        c.ex      = cand_ex[w*EB +: EB];
        c.payload = cand_payload[w*PW +: PW];
        return c;
    endfunction

    function automatic bit busy(input int k, input int w, input int r);
        bit cleared;
        cleared = mbyp[k] && wb_valid && wb_eop && int'(wb_wid) == w && int'(wb_rd) == r;
        return r != 0 && mp[k][w][r] && !cleared;
    endfunction

    function automatic int pick(input int k);
        if (reset || (mdv[k] && !disp_ready)) return -1;
        for (int i = 0; i < NW; i++) begin
            int w;
            issue_cand_t c;
            w = (marb[k] == ARB_FIXED) ? i : (mptr[k] + i) % NW;
            c = cand_of(w);
            if (cand_valid[w] && !busy(k, w, int'(c.rs1)) && !busy(k, w, int'(c.rs2))
                && !busy(k, w, int'(c.rs3)) && !(c.wb && busy(k, w, int'(c.rd))))
                return w;
        end
        return -1;
    endfunction

    // compare process: outputs are settled at the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [NW-1:0] exp_cr;
            mwin[k] = pick(k);
            exp_cr  = (mwin[k] < 0) ? '0 : NW'(1) << mwin[k];
            if (chk_en) begin
                chk($sformatf("cand_ready[%0d]", k), 64'(cr[k]), 64'(exp_cr));
                chk($sformatf("disp_valid[%0d]", k), 64'(dv[k]), 64'(mdv[k]));
                chk($sformatf("perf_stalls[%0d]", k), 64'(ps[k]), 64'(mst[k]));
                if (mdv[k]) begin
                    chk($sformatf("disp_wid[%0d]", k), 64'(dw[k]), 64'(mwid[k]));
                    chk($sformatf("disp_ex[%0d]", k), 64'(dx[k]), 64'(mex[k]));
                    chk($sformatf("disp_payload[%0d]", k), dp[k], mpay[k]);
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                foreach (mp[k][w, r]) mp[k][w][r] = 1'b0;
                mptr[k] = 0;
                mdv[k]  = 1'b0;
                mst[k]  = '0;
            end else begin
                int w;
                issue_cand_t c;
                w = mwin[k];
                if (wb_valid && wb_eop) mp[k][wb_wid][wb_rd] = 1'b0;
                if (w >= 0) begin
                    c = cand_of(w);
                    if (c.wb && c.rd != 0) mp[k][w][c.rd] = 1'b1;
                    mptr[k] = (w + 1) % NW;
                    mdv[k]  = 1'b1;
                    mwid[k] = w;
                    mex[k]  = c.ex;
                    mpay[k] = c.payload;
                end else if (disp_ready) begin
                    mdv[k] = 1'b0;
                end
                if (|cand_valid && w < 0) mst[k] = mst[k] + 32'd1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_cand(input int w, input bit v, input bit wbb, input int rd,
                            input int rs1, input int rs2, input int rs3,
                            input int ex, input logic [63:0] pay);
        cand_valid[w]          = v;
        cand_wb[w]             = wbb;
        cand_rd[w*RB +: RB]    = RB'(rd);
        cand_rs1[w*RB +: RB]   = RB'(rs1);
        cand_rs2[w*RB +: RB]   = RB'(rs2);
        cand_rs3[w*RB +: RB]   = RB'(rs3);
        cand_ex[w*EB +: EB]    = EB'(ex);
        cand_payload[w*PW +: PW] = pay;
    endtask

    task automatic set_wb(input bit v, input int wid, input int rd, input bit eop);
        wb_valid = v;
        wb_wid   = WBW'(wid);
        wb_rd    = RB'(rd);
        wb_eop   = eop;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] s0, s1;
        logic [63:0] snap;
        reset = 1'b1;
        disp_ready = 1'b1;
        cand_valid = '0; cand_wb = '0; cand_rd = '0; cand_rs1 = '0;
        cand_rs2 = '0; cand_rs3 = '0; cand_ex = '0; cand_payload = '0;
        set_wb(0, 0, 0, 0);

        tick();
        chk_en = 1'b1;
        tick();
        settle();
        chk("rst_disp_valid0", 64'(dv[0]), 64'd0);
        chk("rst_cand_ready0", 64'(cr[0]), 64'd0);
        chk("rst_stalls1", 64'(ps[1]), 64'd0);
        reset = 1'b0;
        tick();

        // ADD r5 <- r1, r2 then dependent r6 <- r5
        set_cand(0, 1, 1, 5, 1, 2, 0, 1, 64'hA0);
        settle();
        chk("add_grant0", 64'(cr[0]), 64'h1);
        chk("add_grant1", 64'(cr[1]), 64'h1);
        tick();
        set_cand(0, 1, 1, 6, 5, 0, 0, 2, 64'hA1);
        settle();
        chk("dep_stall0", 64'(cr[0]), 64'h0);
        chk("dep_stall1", 64'(cr[1]), 64'h0);
        chk("add_payload0", dp[0], 64'hA0);
        tick();
        settle();
        chk("dep_stall0_b", 64'(cr[0]), 64'h0);
        tick();
        set_wb(1, 0, 5, 1);
        settle();
        chk("bypass_grant0", 64'(cr[0]), 64'h1);
        chk("nobypass_wait1", 64'(cr[1]), 64'h0);
        tick();
        set_wb(0, 0, 0, 0);
        settle();
        chk("rd6_busy0", 64'(cr[0]), 64'h0);
        chk("nobypass_grant1", 64'(cr[1]), 64'h1);
        tick();
        cand_valid = '0;

        // multi-beat writeback: only the eop beat clears
        set_cand(2, 1, 1, 9, 0, 0, 0, 3, 64'hC2);
        tick();
        cand_valid = '0;
        set_wb(1, 2, 9, 0);
        tick();
        settle();
        chk("mb_pend0", 64'(u_dut0.pending[2][9]), 64'h1);
        chk("mb_pend1", 64'(u_dut1.pending[2][9]), 64'h1);
        set_wb(1, 2, 9, 1);
        tick();
        set_wb(0, 0, 0, 0);
        settle();
        chk("mb_clear0", 64'(u_dut0.pending[2][9]), 64'h0);
        chk("mb_clear1", 64'(u_dut1.pending[2][9]), 64'h0);

        // set and clear of the same (w1, r7) in one cycle
        set_cand(1, 1, 1, 7, 0, 0, 0, 0, 64'hD1);
        tick();
        cand_valid = '0;
        tick();
        set_cand(1, 1, 1, 7, 0, 0, 0, 0, 64'hD2);
        set_wb(1, 1, 7, 1);
        settle();
        chk("setclr_grant0", 64'(cr[0]), 64'h2);
        chk("setclr_grant1", 64'(cr[1]), 64'h0);
        tick();
        cand_valid = '0;
        set_wb(0, 0, 0, 0);
        settle();
        chk("setclr_pend0", 64'(u_dut0.pending[1][7]), 64'h1);
        chk("setclr_pend1", 64'(u_dut1.pending[1][7]), 64'h0);
        set_wb(1, 1, 7, 1);
        tick();
        set_wb(0, 0, 0, 0);

        // r0 never stalls
        set_cand(3, 1, 1, 0, 0, 0, 0, 1, 64'hE3);
        settle();
        chk("r0_grant0", 64'(cr[0]), 64'h8);
        tick();
        settle();
        chk("r0_again0", 64'(cr[0]), 64'h8);
        chk("r0_again1", 64'(cr[1]), 64'h8);
        chk("r0_pend0", 64'(u_dut0.pending[3][0]), 64'h0);
        tick();

        // all warps hazard-free: RR rotates, fixed picks warp 0
        for (int w = 0; w < NW; w++) set_cand(w, 1, 0, 0, 0, 0, 0, w, 64'hB0 + 64'(w));
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("rr_order%0d", i), 64'(cr[0]), 64'(1 << (i % NW)));
            chk($sformatf("fixed_order%0d", i), 64'(cr[1]), 64'h1);
            tick();
        end

        // back-pressure for 5 cycles
        disp_ready = 1'b0;
        s0 = ps[0];
        s1 = ps[1];
        snap = dp[0];
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_ready0", 64'(cr[0]), 64'h0);
            chk("bp_valid0", 64'(dv[0]), 64'h1);
            chk("bp_stable0", dp[0], snap);
            tick();
        end
        chk("bp_stalls0", 64'(ps[0]), 64'(s0 + 32'd5));
        chk("bp_stalls1", 64'(ps[1]), 64'(s1 + 32'd5));

        // reset while back-pressured
        reset = 1'b1;
        tick();
        settle();
        chk("midrst_valid0", 64'(dv[0]), 64'h0);
        chk("midrst_valid1", 64'(dv[1]), 64'h0);
        chk("midrst_pend0", 64'(|u_dut0.pending), 64'h0);
        chk("midrst_pend1", 64'(|u_dut1.pending), 64'h0);
        reset = 1'b0;
        disp_ready = 1'b1;
        cand_valid = '0;
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int w = 0; w < NW; w++)
                set_cand(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 3)), {$urandom, $urandom});
            set_wb(1'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)),
                   int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
            disp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        cand_valid = '0;
        set_wb(0, 0, 0, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
